// File: rtl/vita_word_align.sv
`default_nettype none
// ============================================================================
// Module   : vita_word_align
// Purpose  : Word-alignment training controller for one VITA LVDS data lane.
//            Watches the parallel word coming out of the bitslip muxer and
//            pulses the muxer's bitslip line until the lane training word is
//            seen MATCH_COUNT times in a row, then reports lock (or failure
//            after MAX_SLIPS unsuccessful slips).
// Ports    : clk           - clock, same domain as the bitslip muxer
//            rst_n         - asynchronous active-low reset
//            align_start_i - pulse, starts/restarts training when not busy
//            din_i         - word from the bitslip muxer output
//            bitslip_o     - one-cycle pulse to the muxer bitslip input
//            busy_o        - training in progress
//            locked_o      - lane aligned
//            failed_o      - MAX_SLIPS exhausted without lock
//            slip_count_o  - slips issued in the current attempt
// Revision : 1.0 - initial release
// ============================================================================
module vita_word_align #(
  parameter int                   DATAWIDTH     = 10,
  parameter logic [DATAWIDTH-1:0] TRAINING      = 10'h3A6,
  parameter int                   MATCH_COUNT   = 16,
  parameter int                   SETTLE_CYCLES = 4,
  parameter int                   MAX_SLIPS     = 20
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 align_start_i,
  input  logic [DATAWIDTH-1:0] din_i,
  output logic                 bitslip_o,
  output logic                 busy_o,
  output logic                 locked_o,
  output logic                 failed_o,
  output logic [7:0]           slip_count_o
);

  localparam int MW = $clog2(MATCH_COUNT + 1);
  localparam int SW = $clog2(SETTLE_CYCLES + 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CHECK  = 3'd1,
    SLIP   = 3'd2,
    SETTLE = 3'd3,
    LOCKED = 3'd4,
    FAIL   = 3'd5
  } state_t;

  state_t         state_q, state_d;
  logic [MW-1:0]  match_q, match_d;
  logic [SW-1:0]  settle_q, settle_d;
  logic [7:0]     slip_q, slip_d;
  logic           bitslip_q, busy_q, locked_q, failed_q;

  // Next-state and counter logic
  always_comb begin
    state_d  = state_q;
    match_d  = match_q;
    settle_d = settle_q;
    slip_d   = slip_q;
    case (state_q)
      IDLE, LOCKED, FAIL: begin
        if (align_start_i) begin
          state_d  = CHECK;
          match_d  = '0;
          settle_d = '0;
          slip_d   = '0;
        end
      end
      CHECK: begin
        if (din_i == TRAINING) begin
          match_d = match_q + MW'(1);
          if (match_q == MW'(MATCH_COUNT - 1)) begin
            state_d = LOCKED;
          end
        end else begin
          match_d = '0;
          if (slip_q < 8'(MAX_SLIPS)) begin
            state_d = SLIP;
            // Counted on entry so slip_count moves together with the pulse.
            slip_d  = slip_q + 8'd1;
          end else begin
            state_d = FAIL;
          end
        end
      end
      SLIP: begin
        state_d  = SETTLE;
        settle_d = SW'(SETTLE_CYCLES);
      end
      SETTLE: begin
        // Wait out the muxer's sel->dout latency before trusting din again.
        if (settle_q <= SW'(1)) begin
          state_d  = CHECK;
          settle_d = '0;
        end else begin
          settle_d = settle_q - SW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, counters and registered outputs (outputs decoded from next state)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      match_q   <= '0;
      settle_q  <= '0;
      slip_q    <= '0;
      bitslip_q <= 1'b0;
      busy_q    <= 1'b0;
      locked_q  <= 1'b0;
      failed_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      match_q   <= match_d;
      settle_q  <= settle_d;
      slip_q    <= slip_d;
      bitslip_q <= (state_d == SLIP);
      busy_q    <= (state_d == CHECK) || (state_d == SLIP) || (state_d == SETTLE);
      locked_q  <= (state_d == LOCKED);
      failed_q  <= (state_d == FAIL);
    end
  end

  assign bitslip_o    = bitslip_q;
  assign busy_o       = busy_q;
  assign locked_o     = locked_q;
  assign failed_o     = failed_q;
  assign slip_count_o = slip_q;

endmodule
`default_nettype wire

// File: tb/tb_vita_word_align.sv
`default_nettype none
// ============================================================================
// Module   : tb_vita_word_align
// Purpose  : Directed self-checking bench for vita_word_align with a
//            behavioural bitslip muxer (lane word = training word rotated by
//            N minus the slips seen, two-cycle slip-to-output latency).
// Revision : 1.0 - initial release
// ============================================================================
module tb_vita_word_align;

  localparam logic [9:0] T = 10'h3A6;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       align_start;
  logic [9:0] din;
  logic       bitslip, busy, locked, failed;
  logic [7:0] slip_count;

  int total = 0;
  int bad   = 0;

  // lane model controls
  int         n_rot   = 0;
  logic       lane_clr = 1'b0;
  logic       ovr_en  = 1'b0;
  logic [9:0] ovr_val = '0;
  int         sl_cnt = 0, sel_p1 = 0, sel_p2 = 0;

  // pulse monitor
  logic       mon_clr = 1'b0;
  int         pulses = 0, since = 1000, min_gap = 1000;
  logic       prev_bs = 1'b0, wide = 1'b0;

  always #5 clk = ~clk;

  vita_word_align dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .align_start_i(align_start),
    .din_i        (din),
    .bitslip_o    (bitslip),
    .busy_o       (busy),
    .locked_o     (locked),
    .failed_o     (failed),
    .slip_count_o (slip_count)
  );

  function automatic logic [9:0] rot(input int k);
    logic [19:0] d;
    d = {T, T} << k;
    return d[19:10];
  endfunction

  always @(posedge clk) begin
    if (lane_clr) begin
      sl_cnt <= 0; sel_p1 <= 0; sel_p2 <= 0;
    end else begin
      if (bitslip) sl_cnt <= sl_cnt + 1;
      sel_p1 <= sl_cnt;
      sel_p2 <= sel_p1;
    end
  end

  always_comb begin
    din = ovr_en ? ovr_val : rot((((n_rot - sel_p2) % 10) + 10) % 10);
  end

  always @(posedge clk) begin
    if (mon_clr) begin
      pulses <= 0; since <= 1000; min_gap <= 1000; prev_bs <= 1'b0; wide <= 1'b0;
    end else begin
      prev_bs <= bitslip;
      if (bitslip && prev_bs) wide <= 1'b1;
      if (bitslip) begin
        pulses <= pulses + 1;
        if (pulses != 0 && since < min_gap) min_gap <= since;
        since <= 1;
      end else begin
        since <= since + 1;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic start_pulse();
    @(negedge clk); align_start = 1'b1;
    @(negedge clk); align_start = 1'b0;
  endtask

  task automatic lane_setup(input int n);
    @(negedge clk);
    n_rot = n; lane_clr = 1'b1; mon_clr = 1'b1;
    @(negedge clk);
    lane_clr = 1'b0; mon_clr = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic wait_done(input int budget, output int cyc);
    cyc = 0;
    while (!(locked || failed) && cyc < budget) begin
      @(negedge clk); cyc++;
    end
  endtask

  task automatic wait_bs(input int budget);
    int c = 0;
    while (!bitslip && c < budget) begin
      @(negedge clk); c++;
    end
  endtask

  initial begin
    int cyc;
    rst_n = 1'b0; align_start = 1'b0;

    // 1: reset with random din and start toggling
    ovr_en = 1'b1; mon_clr = 1'b1;
    repeat (2) @(negedge clk);
    mon_clr = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      ovr_val = 10'($urandom);
      align_start = 1'($urandom);
    end
    #1;
    chk("rst_bitslip", bitslip, 0);
    chk("rst_busy", busy, 0);
    chk("rst_locked", locked, 0);
    chk("rst_failed", failed, 0);
    chk("rst_slipcnt", slip_count, 0);
    chk("rst_pulses", pulses, 0);
    @(negedge clk); align_start = 1'b0; rst_n = 1'b1; ovr_en = 1'b0;
    repeat (2) @(negedge clk);
    chk("idle_busy", busy, 0);

    // 2: aligned lane, lock 17 cycles after the start cycle
    lane_setup(0);
    start_pulse();
    chk("t2_busy_c1", busy, 1);
    chk("t2_locked_c1", locked, 0);
    repeat (15) @(negedge clk);
    chk("t2_locked_c16", locked, 0);
    @(negedge clk);
    chk("t2_locked_c17", locked, 1);
    chk("t2_busy_c17", busy, 0);
    chk("t2_slipcnt", slip_count, 0);
    chk("t2_pulses", pulses, 0);

    // 3: rotated by 3, with a start pulse during training that must be ignored
    lane_setup(3);
    start_pulse();
    cyc = 0;
    while (!(locked || failed) && cyc < 200) begin
      @(negedge clk); cyc++;
      align_start = (cyc == 4);
    end
    align_start = 1'b0;
    chk("t3_lock_cycles", cyc, 34);
    chk("t3_locked", locked, 1);
    chk("t3_slipcnt", slip_count, 3);
    chk("t3_pulses", pulses, 3);
    chk("t3_width", wide, 0);
    chk("t3_min_gap", min_gap, 6);

    // 4: din stuck at zero -> 20 slips then failure
    lane_setup(0);
    ovr_en = 1'b1; ovr_val = 10'h000;
    start_pulse();
    wait_done(400, cyc);
    chk("t4_fail_cycles", cyc, 121);
    chk("t4_failed", failed, 1);
    chk("t4_locked", locked, 0);
    chk("t4_busy", busy, 0);
    chk("t4_slipcnt", slip_count, 20);
    chk("t4_pulses", pulses, 20);
    repeat (10) @(negedge clk);
    chk("t4_hold_failed", failed, 1);
    chk("t4_hold_slipcnt", slip_count, 20);

    // 5: slip-immune aligned stream, one corrupted word at the 15th check
    lane_setup(0);
    ovr_en = 1'b1; ovr_val = T;
    start_pulse();
    repeat (14) @(negedge clk);
    ovr_val = T ^ 10'h001;
    @(negedge clk);
    ovr_val = T;
    cyc = 15;
    while (!(locked || failed) && cyc < 200) begin
      @(negedge clk); cyc++;
    end
    chk("t5_lock_cycles", cyc, 36);
    chk("t5_locked", locked, 1);
    chk("t5_slipcnt", slip_count, 1);
    chk("t5_pulses", pulses, 1);
    start_pulse();
    chk("t5_restart_locked", locked, 0);
    chk("t5_restart_busy", busy, 1);
    chk("t5_restart_slipcnt", slip_count, 0);
    repeat (16) @(negedge clk);
    chk("t5_relock", locked, 1);

    // 6: reset during SETTLE, then during SLIP, then clean retrain
    lane_setup(0);
    ovr_en = 1'b1; ovr_val = 10'h000;
    start_pulse();
    wait_bs(20);
    chk("t6_bs_seen", bitslip, 1);
    @(negedge clk);
    chk("t6_settle_busy", busy, 1);
    chk("t6_settle_bs", bitslip, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_rst_busy", busy, 0);
    chk("t6_rst_slipcnt", slip_count, 0);
    chk("t6_rst_bs", bitslip, 0);
    @(negedge clk); rst_n = 1'b1;
    start_pulse();
    wait_bs(20);
    chk("t6_bs_seen2", bitslip, 1);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_slip_bs", bitslip, 0);
    chk("t6_rst_slip_busy", busy, 0);
    mon_clr = 1'b1;
    @(negedge clk); mon_clr = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    repeat (10) @(negedge clk);
    chk("t6_no_partial", pulses, 0);
    chk("t6_idle_busy", busy, 0);
    ovr_en = 1'b0;
    lane_setup(2);
    start_pulse();
    chk("t6_retrain_slipcnt0", slip_count, 0);
    wait_done(200, cyc);
    chk("t6_retrain_locked", locked, 1);
    chk("t6_retrain_slipcnt", slip_count, 2);
    chk("t6_retrain_pulses", pulses, 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
